imm_gen_pipe: RTL and testbench
===============================

// Module: imm_gen_pipe
// PURPOSE
//  Pipelined immediate generator for the decode stage. Takes a raw RV32I/RV64I
//  instruction word, selects the format (I/S/B/U/J) from the opcode, and builds
//  the XLEN-bit immediate. I-type zero-extend and shift-amount modes are supported.
//  Results are queued in a DEPTH-entry in-order buffer with valid/ready on both
//  sides, so decode can stall independently of execute.
// PARAMETERS
//  XLEN   32  datapath width; legal values 32 or 64
//  DEPTH  2   result buffer entries; power of two, >=2
//  TAG_W  5   width of the sideband tag carried unchanged with each result (rd/ROB id)
// PORTS
//  clk          in   1      single clock, rising edge
//  rst_n        in   1      asynchronous, active-low reset
//  flush        in   1      synchronous discard of all buffered results
//  in_valid     in   1      instruction present
//  in_ready     out  1      buffer can accept this cycle
//  in_inst      in   32     raw instruction word
//  in_zext      in   1      zero-extend 12-bit I-type immediate (unsigned op)
//  in_tag       in   TAG_W  sideband tag
//  out_valid    out  1      result available
//  out_ready    in   1      consumer takes result this cycle
//  out_imm      out  XLEN   extended immediate
//  out_fmt      out  3      0=I 1=S 2=B 3=U 4=J 7=none
//  out_illegal  out  1      opcode not recognised
//  out_tag      out  TAG_W  tag of this result
// BEHAVIOUR
//  - Reset (rst_n low, asynchronous): count=0, read/write pointers=0, out_valid=0,
//    in_ready=0 while rst_n low, 1 from the first clk edge after release.
//  - All out_* data ports are driven 0 whenever out_valid=0.
//  - Decode is combinational on in_inst; result, fmt, illegal and tag are written at push.
//  - Opcode [6:0] decode:
//    - 0000011/0010011/1100111/1110011 -> I: sext(inst[31:20]).
//      If in_zext=1: zext(inst[31:20]).
//      OP-IMM shifts (funct3 001/101): zext(inst[24:20]) for XLEN=32, zext(inst[25:20]) for XLEN=64;
//      in_zext is ignored.
//    - 0100011 -> S: sext({inst[31:25],inst[11:7]}).
//    - 1100011 -> B: sext({inst[31],inst[7],inst[30:25],inst[11:8],1'b0}).
//    - 0110111/0010111 -> U: sext({inst[31:12],12'b0}). Sign-extends above bit 31 when XLEN=64.
//    - 1101111 -> J: sext({inst[31],inst[19:12],inst[20],inst[30:21],1'b0}).
//    - Any other opcode -> imm=0, fmt=7, illegal=1. The result is still queued, not dropped.
//  - Buffer and handshake:
//    - push = in_valid & in_ready; pop = out_valid & out_ready.
//    - in_ready = (count<DEPTH) & ~flush. It does not depend on out_ready, so a full
//      buffer refuses input even in a cycle with a pop.
//    - out_valid = (count!=0). Output is the head entry, strictly in push order.
//    - Latency: an entry pushed at edge N is visible with out_valid=1 after edge N.
//      There is no same-cycle bypass.
//    - Simultaneous push and pop: count unchanged, both pointers advance.
//    - Pointers wrap modulo DEPTH.
//    - out_* stay stable while out_valid=1 and out_ready=0.
//  - flush: at the edge it is sampled high, count=0 and pointers=0. Any pop or push in
//    that cycle is void; in_ready is already 0. Flush while empty is a no-op.
//  - Reset asserted mid-operation discards all entries immediately; out_valid falls
//    without waiting for clk.
// TESTING
//  1. Push 0xFFF00093 (addi x1,x0,-1), in_zext=0, out_ready=1
//     -> next cycle out_imm=0xFFFFFFFF, fmt=0, illegal=0.
//  2. Repeat test 1 with in_zext=1 -> out_imm=0x00000FFF.
//     Push 0x01F09093 (slli x1,x1,31) with in_zext=1 -> out_imm=0x0000001F.
//  3. Push 0xFE112E23 (sw x1,-4(x2)) -> out_imm=0xFFFFFFFC, fmt=1.
//     Push 0x12345537 (lui) -> out_imm=0x12345000, fmt=3.
//     For XLEN=64, push 0x80000537 -> out_imm=0xFFFFFFFF80000000.
//  4. Push 0x00000000 -> out_imm=0, fmt=7, illegal=1, out_valid=1 one cycle later.
//  5. Hold out_ready=0 and offer 3 pushes, tags 1,2,3 (DEPTH=2)
//     -> tags 1,2 accepted, in_ready=0 on the third.
//     Raise out_ready -> tags pop as 1,2,3 and data never changes while stalled.
//  6. With count=2, pulse flush while in_valid=1 -> next cycle out_valid=0, in_ready=1,
//     offered word lost. Drop rst_n between edges with count=1 -> out_valid=0 at once.

Source files
------------

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: decode-stage immediate generator.
// The immediate is decoded combinationally from the instruction word and
// written, with its format code and sideband tag, into a small in-order buffer.
// Both the input and the output side use valid/ready handshakes.
module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_inst,
  input  logic             in_zext,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_fmt,
  output logic             out_illegal,
  output logic [TAG_W-1:0] out_tag
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  localparam logic [2:0] FMT_I    = 3'd0;
  localparam logic [2:0] FMT_S    = 3'd1;
  localparam logic [2:0] FMT_B    = 3'd2;
  localparam logic [2:0] FMT_U    = 3'd3;
  localparam logic [2:0] FMT_J    = 3'd4;
  localparam logic [2:0] FMT_NONE = 3'd7;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  logic [XLEN-1:0]  dec_imm;
  logic [2:0]       dec_fmt;
  logic             dec_ill;

  logic [XLEN-1:0]  imm_q [DEPTH];
  logic [2:0]       fmt_q [DEPTH];
  logic             ill_q [DEPTH];
  logic [TAG_W-1:0] tag_q [DEPTH];

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             rdy_q;
  logic             push, pop;

  logic [6:0]       opc;
  logic [2:0]       funct3;

  assign opc    = in_inst[6:0];
  assign funct3 = in_inst[14:12];

  // Format select and immediate assembly from the raw instruction word.
  always_comb begin
    dec_imm = '0;
    dec_fmt = FMT_NONE;
    dec_ill = 1'b1;
    case (opc)
      OP_LOAD, OP_IMM, OP_JALR, OP_SYSTEM: begin
        dec_fmt = FMT_I;
        dec_ill = 1'b0;
        // Shift amounts are unsigned and never sign-extended, so in_zext is moot.
        if (opc == OP_IMM && (funct3 == 3'b001 || funct3 == 3'b101)) begin
          if (XLEN == 64) dec_imm = XLEN'(in_inst[25:20]);
          else            dec_imm = XLEN'(in_inst[24:20]);
        end else if (in_zext) begin
          dec_imm = XLEN'(in_inst[31:20]);
        end else begin
          dec_imm = XLEN'($signed(in_inst[31:20]));
        end
      end
      OP_STORE: begin
        dec_fmt = FMT_S;
        dec_ill = 1'b0;
        dec_imm = XLEN'($signed({in_inst[31:25], in_inst[11:7]}));
      end
      OP_BRANCH: begin
        dec_fmt = FMT_B;
        dec_ill = 1'b0;
        dec_imm = XLEN'($signed({in_inst[31], in_inst[7], in_inst[30:25],
                                 in_inst[11:8], 1'b0}));
      end
      OP_LUI, OP_AUIPC: begin
        dec_fmt = FMT_U;
        dec_ill = 1'b0;
        dec_imm = XLEN'($signed({in_inst[31:12], 12'b0}));
      end
      OP_JAL: begin
        dec_fmt = FMT_J;
        dec_ill = 1'b0;
        dec_imm = XLEN'($signed({in_inst[31], in_inst[19:12], in_inst[20],
                                 in_inst[30:21], 1'b0}));
      end
      default: begin
        dec_imm = '0;
        dec_fmt = FMT_NONE;
        dec_ill = 1'b1;
      end
    endcase
  end

  // in_ready ignores out_ready on purpose: a full buffer never accepts on a pop cycle.
  assign in_ready  = rdy_q & (cnt_q < DEPTH_C) & ~flush;
  assign out_valid = (cnt_q != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // Next pointer/count state; flush voids any pop in the same cycle.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  // Control registers; rdy_q holds off in_ready until the first edge after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      rdy_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      rdy_q    <= 1'b1;
    end
  end

  // Buffer storage; contents are only observable through out_valid, so no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      imm_q[wr_ptr_q] <= dec_imm;
      fmt_q[wr_ptr_q] <= dec_fmt;
      ill_q[wr_ptr_q] <= dec_ill;
      tag_q[wr_ptr_q] <= in_tag;
    end
  end

  assign out_imm     = out_valid ? imm_q[rd_ptr_q] : '0;
  assign out_fmt     = out_valid ? fmt_q[rd_ptr_q] : 3'd0;
  assign out_illegal = out_valid ? ill_q[rd_ptr_q] : 1'b0;
  assign out_tag     = out_valid ? tag_q[rd_ptr_q] : '0;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe at XLEN=32, DEPTH=2, TAG_W=5.
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_inst;
  logic        in_zext;
  logic [4:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_imm;
  logic [2:0]  out_fmt;
  logic        out_illegal;
  logic [4:0]  out_tag;

  int n_vec = 0;
  int n_err = 0;

  imm_gen_pipe #(.XLEN(32), .DEPTH(2), .TAG_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst),
    .in_zext(in_zext), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_imm(out_imm),
    .out_fmt(out_fmt), .out_illegal(out_illegal), .out_tag(out_tag)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] inst;
    logic        zext;
    logic [4:0]  tag;
    logic [31:0] imm;
    logic [2:0]  fmt;
    logic        ill;
  } vec_t;

  vec_t vecs[17];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Advance one full clock; returns just after the falling edge, inputs settled.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  initial begin
    vecs[0]  = '{32'hFFF00093, 1'b0, 5'd1,  32'hFFFFFFFF, 3'd0, 1'b0}; // addi -1
    vecs[1]  = '{32'hFFF00093, 1'b1, 5'd2,  32'h00000FFF, 3'd0, 1'b0}; // addi zext
    vecs[2]  = '{32'h01F09093, 1'b1, 5'd3,  32'h0000001F, 3'd0, 1'b0}; // slli 31
    vecs[3]  = '{32'h4050D093, 1'b0, 5'd4,  32'h00000005, 3'd0, 1'b0}; // srai 5
    vecs[4]  = '{32'hFE112E23, 1'b0, 5'd5,  32'hFFFFFFFC, 3'd1, 1'b0}; // sw -4
    vecs[5]  = '{32'h12345537, 1'b0, 5'd6,  32'h12345000, 3'd3, 1'b0}; // lui
    vecs[6]  = '{32'h80000517, 1'b0, 5'd7,  32'h80000000, 3'd3, 1'b0}; // auipc
    vecs[7]  = '{32'h00000000, 1'b0, 5'd8,  32'h00000000, 3'd7, 1'b1}; // zero word
    vecs[8]  = '{32'h00208463, 1'b0, 5'd9,  32'h00000008, 3'd2, 1'b0}; // beq +8
    vecs[9]  = '{32'hFE000EE3, 1'b0, 5'd10, 32'hFFFFFFFC, 3'd2, 1'b0}; // beq -4
    vecs[10] = '{32'h001000EF, 1'b0, 5'd11, 32'h00000800, 3'd4, 1'b0}; // jal +2048
    vecs[11] = '{32'hFFFFF06F, 1'b0, 5'd12, 32'hFFFFFFFE, 3'd4, 1'b0}; // jal -2
    vecs[12] = '{32'h80002083, 1'b0, 5'd13, 32'hFFFFF800, 3'd0, 1'b0}; // lw -2048
    vecs[13] = '{32'hFFF09067, 1'b0, 5'd14, 32'hFFFFFFFF, 3'd0, 1'b0}; // jalr f3=001: not a shift
    vecs[14] = '{32'h00100073, 1'b0, 5'd15, 32'h00000001, 3'd0, 1'b0}; // ebreak
    vecs[15] = '{32'h00208033, 1'b0, 5'd16, 32'h00000000, 3'd7, 1'b1}; // add: no immediate
    vecs[16] = '{32'h80017093, 1'b1, 5'd31, 32'h00000800, 3'd0, 1'b0}; // andi zext

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_inst = '0;
    in_zext = 1'b0; in_tag = '0; out_ready = 1'b0;

    #12;
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_in_ready",  {31'b0, in_ready},  32'd0);
    chk("rst_out_imm",   out_imm,            32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rel_in_ready_before_edge", {31'b0, in_ready}, 32'd0);
    tick();
    chk("rel_in_ready_after_edge", {31'b0, in_ready}, 32'd1);
    chk("rel_out_valid", {31'b0, out_valid}, 32'd0);

    // Table-driven single push/pop per vector.
    for (int i = 0; i < 17; i++) begin
      in_valid = 1'b1; in_inst = vecs[i].inst; in_zext = vecs[i].zext;
      in_tag = vecs[i].tag; out_ready = 1'b0;
      #1;
      chk($sformatf("v%0d_in_ready", i), {31'b0, in_ready}, 32'd1);
      chk($sformatf("v%0d_no_bypass", i), {31'b0, out_valid}, 32'd0);
      tick();
      in_valid = 1'b0; in_inst = 32'hDEADBEEF; in_zext = ~vecs[i].zext;
      #1;
      chk($sformatf("v%0d_valid", i), {31'b0, out_valid}, 32'd1);
      chk($sformatf("v%0d_imm", i), out_imm, vecs[i].imm);
      chk($sformatf("v%0d_fmt", i), {29'b0, out_fmt}, {29'b0, vecs[i].fmt});
      chk($sformatf("v%0d_ill", i), {31'b0, out_illegal}, {31'b0, vecs[i].ill});
      chk($sformatf("v%0d_tag", i), {27'b0, out_tag}, {27'b0, vecs[i].tag});
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk($sformatf("v%0d_popped", i), {31'b0, out_valid}, 32'd0);
      chk($sformatf("v%0d_zero_imm", i), out_imm, 32'd0);
    end

    // Back-pressure: tags 1,2 fill the buffer, tag 3 is refused until space frees.
    out_ready = 1'b0; in_valid = 1'b1; in_zext = 1'b0;
    in_inst = 32'hFFF00093; in_tag = 5'd1; #1;
    chk("bp_t1_ready", {31'b0, in_ready}, 32'd1);
    tick();
    in_inst = 32'hFE112E23; in_tag = 5'd2; #1;
    chk("bp_t2_ready", {31'b0, in_ready}, 32'd1);
    tick();
    in_inst = 32'h12345537; in_tag = 5'd3; #1;
    for (int k = 0; k < 3; k++) begin
      chk("bp_full_ready", {31'b0, in_ready}, 32'd0);
      chk("bp_stall_tag", {27'b0, out_tag}, 32'd1);
      chk("bp_stall_imm", out_imm, 32'hFFFFFFFF);
      tick();
    end
    out_ready = 1'b1; #1;
    chk("bp_full_pop_ready", {31'b0, in_ready}, 32'd0);
    tick();
    chk("bp_pop1_tag", {27'b0, out_tag}, 32'd2);
    chk("bp_pop1_imm", out_imm, 32'hFFFFFFFC);
    chk("bp_pop1_ready", {31'b0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    chk("bp_pop2_tag", {27'b0, out_tag}, 32'd3);
    chk("bp_pop2_imm", out_imm, 32'h12345000);
    chk("bp_pop2_fmt", {29'b0, out_fmt}, 32'd3);
    tick();
    chk("bp_drained", {31'b0, out_valid}, 32'd0);
    out_ready = 1'b0;

    // Flush with count=2 and a word offered: all discarded.
    in_valid = 1'b1; in_inst = 32'h001000EF; in_tag = 5'd4; #1;
    tick();
    in_tag = 5'd5; tick();
    in_tag = 5'd6; flush = 1'b1; #1;
    chk("fl_ready_during", {31'b0, in_ready}, 32'd0);
    tick();
    flush = 1'b0; in_valid = 1'b0; #1;
    chk("fl_out_valid", {31'b0, out_valid}, 32'd0);
    chk("fl_in_ready", {31'b0, in_ready}, 32'd1);
    chk("fl_out_tag", {27'b0, out_tag}, 32'd0);
    tick();
    chk("fl_word_lost", {31'b0, out_valid}, 32'd0);

    // Flush while empty is harmless; next push works from a clean state.
    flush = 1'b1; tick(); flush = 1'b0;
    in_valid = 1'b1; in_inst = 32'h00208463; in_tag = 5'd9; #1;
    tick();
    in_valid = 1'b0; #1;
    chk("fl_empty_then_push_tag", {27'b0, out_tag}, 32'd9);
    chk("fl_empty_then_push_imm", out_imm, 32'h00000008);

    // Asynchronous reset between edges with count=1.
    #2;
    rst_n = 1'b0; #1;
    chk("arst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("arst_in_ready", {31'b0, in_ready}, 32'd0);
    chk("arst_out_imm", out_imm, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("arst_rel_ready", {31'b0, in_ready}, 32'd1);
    chk("arst_rel_valid", {31'b0, out_valid}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end

endmodule
